// File: rtl/fft_core_pkg.sv
// Shared definitions for the 32-point radix-2 FFT core: sizes, state
// encoding, twiddle ROM and the input bit-reversal helper.
package fft_core_pkg;

  localparam int WORDSIZE  = 16;
  localparam int ADDRSIZE  = 3;
  localparam int NUMSTAGES = 5;
  localparam int NUMPOINTS = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LDRAM   = 3'd1,
    RAMRDY  = 3'd2,
    RUNNING = 3'd3,
    DONE    = 3'd4,
    OUTPUT  = 3'd5
  } state_t;

  // W^k = exp(-j*2*pi*k/32) as {re, im}, each signed and scaled by 64.
  localparam logic [WORDSIZE-1:0] TWIDDLE_ROM [16] = '{
    16'h4000, 16'h3FF4, 16'h3BE8, 16'h35DC,
    16'h2DD3, 16'h24CB, 16'h18C5, 16'h0CC1,
    16'h00C0, 16'hF4C1, 16'hE8C5, 16'hDCCB,
    16'hD3D3, 16'hCBDC, 16'hC5E8, 16'hC1F4
  };

  // Reverses the five address bits so loading leaves samples in DIT order.
  function automatic logic [4:0] bitrev5(input logic [4:0] n);
    return {n[0], n[1], n[2], n[3], n[4]};
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 butterfly with a halving scale on both outputs.
module fft_butterfly
  import fft_core_pkg::*;
(
  input  logic [WORDSIZE-1:0] i_a,
  input  logic [WORDSIZE-1:0] i_b,
  input  logic [WORDSIZE-1:0] i_w,
  output logic [WORDSIZE-1:0] o_a,
  output logic [WORDSIZE-1:0] o_b
);

  logic signed [10:0] w_aRe, w_aIm;
  logic signed [16:0] w_bRe, w_bIm, w_wRe, w_wIm;
  logic signed [16:0] w_pRe, w_pIm;
  logic signed [10:0] w_tRe, w_tIm;
  logic signed [10:0] w_sumRe, w_sumIm, w_difRe, w_difIm;

  assign w_aRe = {{3{i_a[15]}}, i_a[15:8]};
  assign w_aIm = {{3{i_a[7]}}, i_a[7:0]};
  assign w_bRe = {{9{i_b[15]}}, i_b[15:8]};
  assign w_bIm = {{9{i_b[7]}}, i_b[7:0]};
  assign w_wRe = {{9{i_w[15]}}, i_w[15:8]};
  assign w_wIm = {{9{i_w[7]}}, i_w[7:0]};

  // Full-width complex product b*W, then truncate the twiddle scaling away.
  assign w_pRe = w_bRe * w_wRe - w_bIm * w_wIm;
  assign w_pIm = w_bRe * w_wIm + w_bIm * w_wRe;
  assign w_tRe = 11'(w_pRe >>> 6);
  assign w_tIm = 11'(w_pIm >>> 6);

  assign w_sumRe = w_aRe + w_tRe;
  assign w_sumIm = w_aIm + w_tIm;
  assign w_difRe = w_aRe - w_tRe;
  assign w_difIm = w_aIm - w_tIm;

  // Halving every stage keeps the result at DFT/32 and inside Q1.7.
  assign o_a = {8'(w_sumRe >>> 1), 8'(w_sumIm >>> 1)};
  assign o_b = {8'(w_difRe >>> 1), 8'(w_difIm >>> 1)};

endmodule

// File: rtl/fft_core.sv
// 32-point in-place DIT FFT: bit-reversed load, 2 butterflies per enabled
// cycle over 5 stages, then natural-order readout four bins per cycle.
module fft_core
  import fft_core_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic                i_ld_data,
  input  logic                i_ld_done,
  input  logic                i_output_data,
  input  logic [WORDSIZE-1:0] i_fft_in0,
  input  logic [WORDSIZE-1:0] i_fft_in1,
  input  logic [WORDSIZE-1:0] i_fft_in2,
  input  logic [WORDSIZE-1:0] i_fft_in3,
  output logic [WORDSIZE-1:0] o_fft_out0,
  output logic [WORDSIZE-1:0] o_fft_out1,
  output logic [WORDSIZE-1:0] o_fft_out2,
  output logic [WORDSIZE-1:0] o_fft_out3,
  output logic                o_done
);

  state_t              r_state;
  logic [ADDRSIZE:0]   r_row;
  logic [ADDRSIZE:0]   r_outRow;
  logic [2:0]          r_stage;
  logic [ADDRSIZE-1:0] r_bfly;
  logic [WORDSIZE-1:0] r_mem [NUMPOINTS];
  logic [WORDSIZE-1:0] r_out0, r_out1, r_out2, r_out3;
  logic                r_done;

  logic                w_loadWe, w_runWe;
  logic [3:0]          w_j0, w_j1, w_tw0, w_tw1;
  logic [4:0]          w_top0, w_bot0, w_top1, w_bot1;
  logic [WORDSIZE-1:0] w_a0, w_b0, w_a1, w_b1;
  logic [ADDRSIZE-1:0] w_rdRow;

  // Top index of butterfly j in stage s: a zero bit inserted at position s.
  function automatic logic [4:0] topIdx(input logic [3:0] j, input logic [2:0] s);
    logic [4:0] jw, mask;
    jw   = {1'b0, j};
    mask = ~(5'h1F << s);
    return ((jw & ~mask) << 1) | (jw & mask);
  endfunction

  // Twiddle index: position inside the group scaled up to the 32-point grid.
  function automatic logic [3:0] twIdx(input logic [3:0] j, input logic [2:0] s);
    logic [3:0] p;
    p = j & ~(4'hF << s);
    return p << (3'd4 - s);
  endfunction

  assign w_loadWe = (r_state == LDRAM) && i_ld_data && !r_row[ADDRSIZE];
  assign w_runWe  = (r_state == RUNNING) && i_en;

  assign w_j0   = {r_bfly, 1'b0};
  assign w_j1   = {r_bfly, 1'b1};
  assign w_top0 = topIdx(w_j0, r_stage);
  assign w_top1 = topIdx(w_j1, r_stage);
  assign w_bot0 = w_top0 | (5'd1 << r_stage);
  assign w_bot1 = w_top1 | (5'd1 << r_stage);
  assign w_tw0  = twIdx(w_j0, r_stage);
  assign w_tw1  = twIdx(w_j1, r_stage);
  assign w_rdRow = r_outRow[ADDRSIZE-1:0];

  fft_butterfly u_bfly0 (
    .i_a(r_mem[w_top0]), .i_b(r_mem[w_bot0]), .i_w(TWIDDLE_ROM[w_tw0]),
    .o_a(w_a0), .o_b(w_b0)
  );

  fft_butterfly u_bfly1 (
    .i_a(r_mem[w_top1]), .i_b(r_mem[w_bot1]), .i_w(TWIDDLE_ROM[w_tw1]),
    .o_a(w_a1), .o_b(w_b1)
  );

  // Sample buffer: loader writes a bit-reversed row, the run writes 4 results.
  always_ff @(posedge clk) begin
    if (w_loadWe) begin
      r_mem[bitrev5({r_row[ADDRSIZE-1:0], 2'd0})] <= i_fft_in0;
      r_mem[bitrev5({r_row[ADDRSIZE-1:0], 2'd1})] <= i_fft_in1;
      r_mem[bitrev5({r_row[ADDRSIZE-1:0], 2'd2})] <= i_fft_in2;
      r_mem[bitrev5({r_row[ADDRSIZE-1:0], 2'd3})] <= i_fft_in3;
    end else if (w_runWe) begin
      r_mem[w_top0] <= w_a0;
      r_mem[w_bot0] <= w_b0;
      r_mem[w_top1] <= w_a1;
      r_mem[w_bot1] <= w_b1;
    end
  end

  // Control FSM with registered done flag and readout rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_row    <= '0;
      r_outRow <= '0;
      r_stage  <= '0;
      r_bfly   <= '0;
      r_out0   <= '0;
      r_out1   <= '0;
      r_out2   <= '0;
      r_out3   <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_ld_data) begin
            r_state <= LDRAM;
            r_row   <= '0;
          end
        end
        LDRAM: begin
          if (w_loadWe) r_row <= r_row + 1'b1;
          if (i_ld_done) r_state <= RAMRDY;
        end
        RAMRDY: begin
          if (i_en) begin
            r_state <= RUNNING;
            r_stage <= '0;
            r_bfly  <= '0;
          end
        end
        RUNNING: begin
          if (i_en) begin
            r_bfly <= r_bfly + 1'b1;
            if (r_bfly == '1) begin
              if (r_stage == 3'(NUMSTAGES - 1)) begin
                r_state  <= DONE;
                r_done   <= 1'b1;
                r_outRow <= '0;
              end else begin
                r_stage <= r_stage + 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (!i_ld_data && i_output_data) begin
            r_state  <= OUTPUT;
            r_out0   <= r_mem[{w_rdRow, 2'd0}];
            r_out1   <= r_mem[{w_rdRow, 2'd1}];
            r_out2   <= r_mem[{w_rdRow, 2'd2}];
            r_out3   <= r_mem[{w_rdRow, 2'd3}];
            r_outRow <= r_outRow + 1'b1;
          end
        end
        OUTPUT: begin
          if (r_outRow[ADDRSIZE]) begin
            r_state  <= IDLE;
            r_done   <= 1'b0;
            r_outRow <= '0;
            r_out0   <= '0;
            r_out1   <= '0;
            r_out2   <= '0;
            r_out3   <= '0;
          end else begin
            r_out0   <= r_mem[{w_rdRow, 2'd0}];
            r_out1   <= r_mem[{w_rdRow, 2'd1}];
            r_out2   <= r_mem[{w_rdRow, 2'd2}];
            r_out3   <= r_mem[{w_rdRow, 2'd3}];
            r_outRow <= r_outRow + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_fft_out0 = r_out0;
  assign o_fft_out1 = r_out1;
  assign o_fft_out2 = r_out2;
  assign o_fft_out3 = r_out3;
  assign o_done     = r_done;

endmodule

// File: tb/tb_fft_core.sv
// Self-checking bench for fft_core: directed transforms with known bins plus
// random frames compared against an integer fixed-point FFT model.
module tb_fft_core;

  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, ldData = 1'b0, ldDone = 1'b0, outputData = 1'b0;
  logic [15:0] fftIn0 = '0, fftIn1 = '0, fftIn2 = '0, fftIn3 = '0;
  logic [15:0] fftOut0, fftOut1, fftOut2, fftOut3;
  logic        done;
  logic [15:0] obs [4];

  int          total = 0;
  int          bad = 0;
  int          mRe [32];
  int          mIm [32];
  logic [15:0] frame [32];
  logic [15:0] expBins [32];

  always #5 clk = ~clk;

  fft_core dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_ld_data(ldData),
    .i_ld_done(ldDone), .i_output_data(outputData),
    .i_fft_in0(fftIn0), .i_fft_in1(fftIn1), .i_fft_in2(fftIn2), .i_fft_in3(fftIn3),
    .o_fft_out0(fftOut0), .o_fft_out1(fftOut1), .o_fft_out2(fftOut2), .o_fft_out3(fftOut3),
    .o_done(done)
  );

  assign obs[0] = fftOut0;
  assign obs[1] = fftOut1;
  assign obs[2] = fftOut2;
  assign obs[3] = fftOut3;

  // ---------------- reference model ----------------
  function automatic int brev(input int n);
    int r = 0;
    for (int b = 0; b < 5; b++) if ((n >> b) & 1) r |= 1 << (4 - b);
    return r;
  endfunction

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int twRe(input int k);
    return rnd(64.0 * $cos(2.0 * PI * real'(k) / 32.0));
  endfunction

  function automatic int twIm(input int k);
    return -rnd(64.0 * $sin(2.0 * PI * real'(k) / 32.0));
  endfunction

  function automatic int wrap8(input int x);
    logic [7:0] v;
    v = x[7:0];
    return int'(signed'(v));
  endfunction

  function automatic int sre(input logic [15:0] w);
    logic [7:0] v;
    v = w[15:8];
    return int'(signed'(v));
  endfunction

  function automatic int sim(input logic [15:0] w);
    logic [7:0] v;
    v = w[7:0];
    return int'(signed'(v));
  endfunction

  function automatic logic [15:0] packC(input int re, input int im);
    logic [7:0] r8, i8;
    r8 = re[7:0];
    i8 = im[7:0];
    return {r8, i8};
  endfunction

  function automatic logic [15:0] randWord();
    int re, im;
    re = int'($urandom_range(127, 0)) - 64;
    im = int'($urandom_range(127, 0)) - 64;
    return packC(re, im);
  endfunction

  task automatic modelLoad(input int rows);
    for (int r = 0; r < rows && r < 8; r++)
      for (int k = 0; k < 4; k++) begin
        mRe[brev(4 * r + k)] = sre(frame[4 * r + k]);
        mIm[brev(4 * r + k)] = sim(frame[4 * r + k]);
      end
  endtask

  // In-place iterative DIT over the model buffer using the scaled butterfly.
  task automatic modelRun();
    int h, k, a, b, wr, wi, prR, prI, tr, ti, ar, ai;
    for (int s = 0; s < 5; s++) begin
      h = 1 << s;
      for (int base = 0; base < 32; base += 2 * h)
        for (int p = 0; p < h; p++) begin
          k = p * (16 / h);
          a = base + p;
          b = a + h;
          wr = twRe(k);
          wi = twIm(k);
          prR = mRe[b] * wr - mIm[b] * wi;
          prI = mRe[b] * wi + mIm[b] * wr;
          tr = prR >>> 6;
          ti = prI >>> 6;
          ar = mRe[a];
          ai = mIm[a];
          mRe[a] = wrap8((ar + tr) >>> 1);
          mIm[a] = wrap8((ai + ti) >>> 1);
          mRe[b] = wrap8((ar - tr) >>> 1);
          mIm[b] = wrap8((ai - ti) >>> 1);
        end
    end
  endtask

  task automatic modelToExp();
    for (int n = 0; n < 32; n++) expBins[n] = packC(mRe[n], mIm[n]);
  endtask

  // ---------------- DUT drivers ----------------
  task automatic doReset();
    rst_n = 1'b0;
    en = 1'b0; ldData = 1'b0; ldDone = 1'b0; outputData = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives `rows` load cycles; rows past 7 carry junk that must be ignored.
  task automatic loadFrame(input int rows);
    @(negedge clk);
    ldData = 1'b1;
    for (int r = 0; r < rows; r++) begin
      @(negedge clk);
      if (r < 8) begin
        fftIn0 = frame[4 * r]; fftIn1 = frame[4 * r + 1];
        fftIn2 = frame[4 * r + 2]; fftIn3 = frame[4 * r + 3];
      end else begin
        fftIn0 = 16'($urandom); fftIn1 = 16'($urandom);
        fftIn2 = 16'($urandom); fftIn3 = 16'($urandom);
      end
    end
    @(negedge clk);
    ldData = 1'b0;
    ldDone = 1'b1;
    @(negedge clk);
    ldDone = 1'b0;
    modelLoad(rows);
  endtask

  // Runs the transform with an optional en-low window and checks done latency.
  task automatic runFft(input string tag, input int pauseAt, input int pauseLen);
    int got, expLat;
    got = -1;
    expLat = 41 + pauseLen;
    en = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = k;
        break;
      end
      if (pauseLen > 0 && k == pauseAt) en = 1'b0;
      if (pauseLen > 0 && k == pauseAt + pauseLen) en = 1'b1;
    end
    en = 1'b0;
    total++;
    if (got != expLat) begin
      bad++;
      $display("[TB] FAIL %s doneLatency: got %0d cycles expected %0d", tag, got, expLat);
    end
    modelRun();
  endtask

  task automatic readout(input string tag);
    outputData = 1'b1;
    @(negedge clk);
    outputData = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (r > 0) @(negedge clk);
      total++;
      if (done !== 1'b1) begin
        bad++;
        $display("[TB] FAIL %s doneRow%0d: got %b expected 1", tag, r, done);
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (obs[k] !== expBins[4 * r + k]) begin
          bad++;
          $display("[TB] FAIL %s bin%0d: got %h expected %h", tag, 4 * r + k, obs[k], expBins[4 * r + k]);
        end
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || {fftOut0, fftOut1, fftOut2, fftOut3} !== 64'd0) begin
      bad++;
      $display("[TB] FAIL %s afterRow7: got done=%b outs=%h expected done=0 outs=0",
               tag, done, {fftOut0, fftOut1, fftOut2, fftOut3});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    doReset();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset done: got %b expected 0", done);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs[k] !== 16'h0000) begin
        bad++;
        $display("[TB] FAIL reset out%0d: got %h expected 0000", k, obs[k]);
      end
    end
    en = 1'b1; outputData = 1'b1; ldDone = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || {fftOut0, fftOut1, fftOut2, fftOut3} !== 64'd0) begin
        bad++;
        $display("[TB] FAIL idleIgnore cyc%0d: got done=%b outs=%h expected 0/0", i, done,
                 {fftOut0, fftOut1, fftOut2, fftOut3});
      end
    end
    en = 1'b0; outputData = 1'b0; ldDone = 1'b0;
  endtask

  task automatic test_impulse(input string tag);
    for (int n = 0; n < 32; n++) frame[n] = 16'h0000;
    frame[0] = 16'h7F00;
    loadFrame(8);
    runFft(tag, 0, 0);
    for (int n = 0; n < 32; n++) expBins[n] = 16'h0300;
    readout(tag);
  endtask

  task automatic test_dc(input int pauseLen);
    for (int n = 0; n < 32; n++) frame[n] = 16'h4000;
    loadFrame(8);
    runFft(pauseLen > 0 ? "dcPause" : "dc", 28, pauseLen);
    for (int n = 0; n < 32; n++) expBins[n] = 16'h0000;
    expBins[0] = 16'h4000;
    readout(pauseLen > 0 ? "dcPause" : "dc");
  endtask

  task automatic test_alternating();
    for (int n = 0; n < 32; n++) frame[n] = n[0] ? 16'hC000 : 16'h4000;
    loadFrame(8);
    runFft("alt", 0, 0);
    for (int n = 0; n < 32; n++) expBins[n] = 16'h0000;
    expBins[16] = 16'h4000;
    readout("alt");
  endtask

  task automatic test_handshake();
    for (int n = 0; n < 32; n++) frame[n] = randWord();
    loadFrame(8);
    runFft("hs", 0, 0);
    modelToExp();
    for (int i = 0; i < 23; i++) begin
      if (i == 20) begin
        ldData = 1'b1;
        outputData = 1'b1;
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1 || {fftOut0, fftOut1, fftOut2, fftOut3} !== 64'd0) begin
        bad++;
        $display("[TB] FAIL hsHold cyc%0d: got done=%b outs=%h expected done=1 outs=0", i, done,
                 {fftOut0, fftOut1, fftOut2, fftOut3});
      end
    end
    ldData = 1'b0;
    outputData = 1'b0;
    readout("hs");
  endtask

  task automatic test_reset_midrun();
    for (int n = 0; n < 32; n++) frame[n] = randWord();
    loadFrame(8);
    en = 1'b1;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (done !== 1'b0 || {fftOut0, fftOut1, fftOut2, fftOut3} !== 64'd0) begin
      bad++;
      $display("[TB] FAIL midReset: got done=%b outs=%h expected 0/0", done,
               {fftOut0, fftOut1, fftOut2, fftOut3});
    end
    @(negedge clk);
    rst_n = 1'b1;
    outputData = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || {fftOut0, fftOut1, fftOut2, fftOut3} !== 64'd0) begin
        bad++;
        $display("[TB] FAIL postResetIdle cyc%0d: got done=%b expected 0", i, done);
      end
    end
    en = 1'b0;
    outputData = 1'b0;
    test_impulse("reload");
  endtask

  task automatic test_back_to_back();
    int rows, pAt, pLen;
    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < 32; n++) frame[n] = randWord();
      rows = (f == 1) ? 11 : 8;
      pAt  = (f == 2) ? int'($urandom_range(35, 2)) : 0;
      pLen = (f == 2) ? int'($urandom_range(6, 1)) : 0;
      loadFrame(rows);
      runFft($sformatf("b2b%0d", f), pAt, pLen);
      modelToExp();
      readout($sformatf("b2b%0d", f));
    end
  endtask

  task automatic test_partial_load();
    for (int n = 0; n < 32; n++) frame[n] = randWord();
    loadFrame(5);
    runFft("partial", 0, 0);
    modelToExp();
    readout("partial");
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] fft_core bench start");
    test_reset();
    test_impulse("impulse");
    test_dc(0);
    test_dc(10);
    test_alternating();
    test_handshake();
    test_reset_midrun();
    test_back_to_back();
    test_partial_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
